seg7_scan_driver: RTL

//  Consumes the four 4-bit display nibbles arr0..arr3 that the data memory exports from words 1015..1018.

---
 rtl/seg7_scan_driver_if.sv | 19 +
 rtl/seg7_scan_driver.sv | 65 ++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display data/control inputs and pin-level outputs of the scan driver
interface seg7_scan_driver_if;
  logic [3:0] arr0, arr1, arr2, arr3;
  logic [3:0] digit_en;
  logic [3:0] dp_mask;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;
  modport master (
    output arr0, arr1, arr2, arr3, digit_en, dp_mask, blank,
    input  an, seg, dp, frame_tick
  );
  modport slave (
    input  arr0, arr1, arr2, arr3, digit_en, dp_mask, blank,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: tear-free 4-digit hex scan for a common-anode 7-segment display
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input logic                clk,
  input logic                reset,
  seg7_scan_driver_if.slave  io
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    snap_q [4];
  logic [3:0]    snap_d [4];
  logic [3:0]    arr [4];
  logic          init_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          ft_q, ft_d;
  logic          tick;
  logic          load;
  assign arr = '{io.arr0, io.arr1, io.arr2, io.arr3};
  always_comb begin
    tick   = cnt_q == CW'(REFRESH_DIV - 1);
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    idx_d  = idx_q + 2'(tick);
    // a new frame is only captured at the 3 -> 0 wrap so a mid-scan store never tears the image
    load   = init_q || (tick && idx_q == 2'd3);
    snap_d = load ? arr : snap_q;
    // the slot's last cycle is dark so the segment change never ghosts onto the next digit
    an_d   = (tick || io.blank || !io.digit_en[idx_q]) ? 4'hF : ~(4'b0001 << idx_q);
    seg_d  = ~HEX[snap_q[idx_q]];
    dp_d   = ~io.dp_mask[idx_q];
    ft_d   = tick && idx_q == 2'd3;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '{default: '0};
      init_q <= 1'b1;
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      ft_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      init_q <= 1'b0;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      ft_q   <= ft_d;
    end
  end
  assign io.an         = an_q;
  assign io.seg        = seg_q;
  assign io.dp         = dp_q;
  assign io.frame_tick = ft_q;
endmodule
